// File: rtl/pipeline_elastic_if.sv
// Handshake bundle for the elastic pipeline: producer side, sink side and occupancy.
interface pipeline_elastic_if #(
  parameter int WIDTH = 128,
  parameter int CNT_W = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] occupancy;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipeline_elastic.sv
// Elastic valid/ready pipeline: backpressure ripples upstream stage by stage
// and bubbles collapse; data registers only load on a stage take.
module pipeline_elastic #(
  parameter int WIDTH = 128,
  parameter int DEPTH = 5,
  parameter int CNT_W = 5
) (
  input logic               clk,
  input logic               reset_n,
  pipeline_elastic_if.slave bus
);

  logic [DEPTH-1:0] v_q;
  logic [DEPTH-1:0] v_d;
  logic [DEPTH-1:0] adv;
  logic [DEPTH-1:0] take;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [CNT_W-1:0] occ_q;
  logic [CNT_W-1:0] occ_d;
  logic             in_ready_c;
  logic             adv_c;

  always_comb begin
    adv   = '0;
    take  = '0;
    adv_c = v_q[DEPTH-1] & bus.out_ready;
    adv[DEPTH-1] = adv_c;
    // Walk from the output stage back so each stage sees the advance of the one ahead.
    for (int i = DEPTH-2; i >= 0; i--) begin
      adv_c  = v_q[i] & (~v_q[i+1] | adv_c);
      adv[i] = adv_c;
    end
    in_ready_c = ~v_q[0] | adv[0];
    take[0]    = bus.in_valid & in_ready_c;
    for (int i = 1; i < DEPTH; i++) begin
      take[i] = v_q[i-1] & (~v_q[i] | adv[i]);
    end
    v_d   = take | (v_q & ~adv);
    occ_d = occ_q + CNT_W'(take[0]) - CNT_W'(adv[DEPTH-1]);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        d_q[i] <= '0;
      end
    end else begin
      v_q   <= v_d;
      occ_q <= occ_d;
      if (take[0]) begin
        d_q[0] <= bus.in_data;
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (take[i]) begin
          d_q[i] <= d_q[i-1];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign bus.occupancy = occ_q;

endmodule
